// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: requester IDs, the
// packed downstream command layout, lock FSM encoding and defaults.
package sram_req_arbiter_pkg;

  // Requester IDs stored in the order FIFO and used as the select value.
  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  // wr + size + addr + wstrb + wdata
  localparam int SRAM_CMD_WD = 71;

  localparam int DEF_MAX_OUTST  = 4;
  localparam int DEF_STARVE_LIM = 3;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_cmd_t;

  // Lock FSM: OPEN re-arbitrates every cycle, HELD replays the captured
  // command until the downstream port accepts it.
  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } lock_state_t;

  function automatic sram_cmd_t pack_cmd(input logic        wr,
                                         input logic [1:0]  size,
                                         input logic [31:0] addr,
                                         input logic [3:0]  wstrb,
                                         input logic [31:0] wdata);
    sram_cmd_t c;
    c.wr    = wr;
    c.size  = size;
    c.addr  = addr;
    c.wstrb = wstrb;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/arb_order_fifo.sv
// One-bit-wide order FIFO recording which requester owns each
// accepted-but-unanswered downstream request. Pointers wrap naturally
// because DEPTH is a power of two.
module arb_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [DEPTH-1:0] ids;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write at the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ids <= '0;
    else if (do_push) ids[wr_ptr] <= push_id;
  end

  // Pointer and occupancy tracking; simultaneous push/pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = ids[rd_ptr];

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between the instruction-fetch and data-access
// requesters. Data has priority unless inst has been starved for
// STARVE_LIM cycles. A stalled downstream command is locked and replayed
// from a registered copy; an order FIFO routes responses back in order.
//
// Handshake: a request transfers when req && addr_ok are high in the same
// cycle; a response transfers in any cycle data_ok is high. Once mem_req is
// raised, mem_req and all mem_* command fields hold until mem_addr_ok.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST  = DEF_MAX_OUTST,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  lock_state_t   lock_state;
  lock_state_t   lock_next;
  logic          locked;
  logic          arb_sel;
  logic          sel;
  logic          sel_q;
  sram_cmd_t     inst_cmd;
  sram_cmd_t     data_cmd;
  sram_cmd_t     live_cmd;
  sram_cmd_t     cmd_q;
  sram_cmd_t     cmd;
  logic [SW-1:0] starve_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;
  logic          accept;
  logic          resp;
  logic          stall;

  assign inst_cmd = pack_cmd(inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata);
  assign data_cmd = pack_cmd(data_wr, data_size, data_addr, data_wstrb, data_wdata);

  // Unlocked arbitration: data first, inst on idle data or starvation.
  always_comb begin
    arb_sel = ARB_ID_DATA;
    if (inst_req && (!data_req || starve_cnt == STARVE_MAX)) arb_sel = ARB_ID_INST;
  end

  assign live_cmd = (arb_sel == ARB_ID_INST) ? inst_cmd : data_cmd;
  assign sel      = locked ? sel_q : arb_sel;
  assign cmd      = locked ? cmd_q : live_cmd;

  // A full order FIFO blocks issue even if a pop lands this cycle.
  assign mem_req   = (locked || inst_req || data_req) && !fifo_full && !reset;
  assign mem_wr    = cmd.wr;
  assign mem_size  = cmd.size;
  assign mem_addr  = cmd.addr;
  assign mem_wstrb = cmd.wstrb;
  assign mem_wdata = cmd.wdata;

  assign accept       = mem_req && mem_addr_ok;
  assign stall        = mem_req && !mem_addr_ok;
  assign inst_addr_ok = accept && (sel == ARB_ID_INST);
  assign data_addr_ok = accept && (sel == ARB_ID_DATA);

  // Responses with nothing outstanding are dropped.
  assign resp         = mem_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = resp && (fifo_head == ARB_ID_INST);
  assign data_data_ok = resp && (fifo_head == ARB_ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Lock FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_state <= LK_OPEN;
    else       lock_state <= lock_next;
  end

  // Lock FSM next state: lock on a stalled issue, release on acceptance.
  always_comb begin
    lock_next = lock_state;
    case (lock_state)
      LK_OPEN: if (stall)  lock_next = LK_HELD;
      LK_HELD: if (accept) lock_next = LK_OPEN;
      default: lock_next = LK_OPEN;
    endcase
  end

  // Lock FSM outputs.
  always_comb begin
    locked = (lock_state == LK_HELD);
  end

  // Capture the winner and its command on the cycle the lock is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= ARB_ID_DATA;
      cmd_q <= '0;
    end else if (lock_state == LK_OPEN && stall) begin
      sel_q <= arb_sel;
      cmd_q <= live_cmd;
    end
  end

  // Starvation counter: counts denied inst cycles, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  arb_order_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_arb_order_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (accept),
    .push_id (sel),
    .pop     (resp),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: one task per scenario with inline
// comparisons; an expected-ID queue tracks response ordering.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUTST(4), .STARVE_LIM(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL rst_inst_addr_ok: got %b want 0", inst_addr_ok); end
    checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL rst_data_addr_ok: got %b want 0", data_addr_ok); end
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL rst_inst_data_ok: got %b want 0", inst_data_ok); end
    checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL rst_data_data_ok: got %b want 0", data_data_ok); end
    tick();
    reset = 1'b0;
    idle_inputs();
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_rst_mem_req: got %b want 0", mem_req); end
    tick();
  endtask

  task automatic test_single_inst();
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
    #2;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL si_mem_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h1c00_0000) begin errors++; $display("FAIL si_mem_addr: got %h want 1c000000", mem_addr); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL si_mem_wr: got %b want 0", mem_wr); end
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL si_inst_addr_ok: got %b want 1", inst_addr_ok); end
    checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL si_data_addr_ok: got %b want 0", data_addr_ok); end
    tick();
    inst_req = 0; mem_addr_ok = 0;
    #2;
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL si_early_data_ok: got %b want 0", inst_data_ok); end
    tick();
    mem_data_ok = 1; mem_rdata = 32'h0280_0000;
    #2;
    checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL si_inst_data_ok: got %b want 1", inst_data_ok); end
    checks++; if (inst_rdata !== 32'h0280_0000) begin errors++; $display("FAIL si_inst_rdata: got %h want 02800000", inst_rdata); end
    checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL si_data_data_ok: got %b want 0", data_data_ok); end
    tick();
    idle_inputs();
  endtask

  task automatic test_both_same_cycle();
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h0000_0080; data_wstrb = 4'hf; data_wdata = 32'h1234_5678;
    mem_addr_ok = 1;
    #2;
    checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL both_data_first: got %b want 1", data_addr_ok); end
    checks++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL both_inst_wait: got %b want 0", inst_addr_ok); end
    checks++; if (mem_addr !== 32'h0000_0080) begin errors++; $display("FAIL both_mem_addr_d: got %h want 00000080", mem_addr); end
    checks++; if ({mem_wr, mem_wstrb} !== 5'b1_1111) begin errors++; $display("FAIL both_mem_wr_wstrb: got %b want 11111", {mem_wr, mem_wstrb}); end
    checks++; if (mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL both_mem_wdata: got %h want 12345678", mem_wdata); end
    tick();
    data_req = 0; data_wr = 0;
    #2;
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL both_inst_second: got %b want 1", inst_addr_ok); end
    checks++; if (mem_addr !== 32'h1c00_0004) begin errors++; $display("FAIL both_mem_addr_i: got %h want 1c000004", mem_addr); end
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0;
    #2;
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin errors++; $display("FAIL both_resp1: got d/i=%b want 10", {data_data_ok, inst_data_ok}); end
    tick();
    mem_rdata = 32'haabb_ccdd;
    #2;
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b01) begin errors++; $display("FAIL both_resp2: got d/i=%b want 01", {data_data_ok, inst_data_ok}); end
    checks++; if (inst_rdata !== 32'haabb_ccdd) begin errors++; $display("FAIL both_inst_rdata: got %h want aabbccdd", inst_rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic exp_id;
    logic rid;
    do_reset();
    inst_req = 1; inst_addr = 32'h1c00_0100;
    data_req = 1; data_addr = 32'h0000_0200;
    mem_addr_ok = 1;
    for (int c = 0; c < 6; c++) begin
      mem_data_ok = (c > 0);
      #2;
      exp_id = (c == 3) ? ARB_ID_INST : ARB_ID_DATA;
      checks++;
      if (inst_addr_ok !== (exp_id == ARB_ID_INST) || data_addr_ok !== (exp_id == ARB_ID_DATA)) begin
        errors++;
        $display("FAIL starve_grant_c%0d: got i/d=%b%b want id=%b", c, inst_addr_ok, data_addr_ok, exp_id);
      end
      if (c > 0) begin
        rid = exp_q.pop_front();
        checks++;
        if (inst_data_ok !== (rid == ARB_ID_INST) || data_data_ok !== (rid == ARB_ID_DATA)) begin
          errors++;
          $display("FAIL starve_resp_c%0d: got i/d=%b%b want id=%b", c, inst_data_ok, data_data_ok, rid);
        end
      end
      exp_q.push_back(exp_id);
      tick();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #2;
    rid = exp_q.pop_front();
    checks++;
    if (inst_data_ok !== (rid == ARB_ID_INST) || data_data_ok !== (rid == ARB_ID_DATA)) begin
      errors++;
      $display("FAIL starve_resp_last: got i/d=%b%b want id=%b", inst_data_ok, data_data_ok, rid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock_hold();
    do_reset();
    data_req = 1; data_addr = 32'h0000_0300; data_wdata = 32'hdead_beef; mem_addr_ok = 0;
    #2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0300) begin errors++; $display("FAIL lock_c0: got req=%b addr=%h want 1/00000300", mem_req, mem_addr); end
    checks++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_c0_addr_ok: got %b want 0", data_addr_ok); end
    tick();
    // Upstream fields change while stalled; the registered copy must win.
    data_addr = 32'h0000_0304; data_wdata = 32'h0; inst_req = 1; inst_addr = 32'h1c00_0200;
    for (int c = 1; c < 3; c++) begin
      #2;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0300 || mem_wdata !== 32'hdead_beef) begin
        errors++;
        $display("FAIL lock_hold_c%0d: got req=%b addr=%h wdata=%h want 1/00000300/deadbeef", c, mem_req, mem_addr, mem_wdata);
      end
      checks++;
      if (inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
        errors++;
        $display("FAIL lock_ack_c%0d: got i/d=%b%b want 00", c, inst_addr_ok, data_addr_ok);
      end
      tick();
    end
    mem_addr_ok = 1;
    #2;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("FAIL lock_release: got i/d=%b want 01", {inst_addr_ok, data_addr_ok}); end
    checks++; if (mem_addr !== 32'h0000_0300) begin errors++; $display("FAIL lock_release_addr: got %h want 00000300", mem_addr); end
    tick();
    data_req = 0;
    #2;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL lock_then_inst: got i/d=%b want 10", {inst_addr_ok, data_addr_ok}); end
    checks++; if (mem_addr !== 32'h1c00_0200) begin errors++; $display("FAIL lock_then_inst_addr: got %h want 1c000200", mem_addr); end
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #2;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL lock_resp_d: got i/d=%b want 01", {inst_data_ok, data_data_ok}); end
    tick();
    #2;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL lock_resp_i: got i/d=%b want 10", {inst_data_ok, data_data_ok}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full_wrap();
    logic rid;
    do_reset();
    mem_addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      inst_req = (c % 2 == 0); data_req = (c % 2 == 1);
      inst_addr = 32'h1c00_1000 + c; data_addr = 32'h0000_1000 + c;
      #2;
      checks++;
      if (inst_addr_ok !== inst_req || data_addr_ok !== data_req) begin
        errors++;
        $display("FAIL full_accept_c%0d: got i/d=%b%b want %b%b", c, inst_addr_ok, data_addr_ok, inst_req, data_req);
      end
      exp_q.push_back(inst_req ? ARB_ID_INST : ARB_ID_DATA);
      tick();
    end
    inst_req = 1; data_req = 0;
    #2;
    checks++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL full_block: got req=%b ack=%b want 0/0", mem_req, inst_addr_ok); end
    tick();
    mem_data_ok = 1;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_block_on_pop: got %b want 0", mem_req); end
    rid = exp_q.pop_front();
    checks++; if (inst_data_ok !== (rid == ARB_ID_INST) || data_data_ok !== (rid == ARB_ID_DATA)) begin errors++; $display("FAIL full_pop0: got i/d=%b%b want id=%b", inst_data_ok, data_data_ok, rid); end
    tick();
    mem_data_ok = 0;
    #2;
    checks++; if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_reassert: got req=%b ack=%b want 1/1", mem_req, inst_addr_ok); end
    exp_q.push_back(ARB_ID_INST);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int c = 0; c < 4; c++) begin
      #2;
      rid = exp_q.pop_front();
      checks++;
      if (inst_data_ok !== (rid == ARB_ID_INST) || data_data_ok !== (rid == ARB_ID_DATA)) begin
        errors++;
        $display("FAIL wrap_resp%0d: got i/d=%b%b want id=%b", c, inst_data_ok, data_data_ok, rid);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    mem_data_ok = 1;
    #2;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL spur_empty: got i/d=%b want 00", {inst_data_ok, data_data_ok}); end
    tick();
    mem_data_ok = 0; mem_addr_ok = 1; inst_req = 1; inst_addr = 32'h1c00_2000;
    tick();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_2000;
    tick();
    data_req = 0; mem_addr_ok = 0;
    #2;
    reset = 1'b1; mem_data_ok = 1;
    #1;
    checks++; if ({inst_data_ok, data_data_ok, mem_req} !== 3'b000) begin errors++; $display("FAIL mid_rst_outputs: got i/d/req=%b want 000", {inst_data_ok, data_data_ok, mem_req}); end
    tick();
    reset = 1'b0;
    #2;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL post_rst_resp: got i/d=%b want 00", {inst_data_ok, data_data_ok}); end
    tick();
    mem_data_ok = 0; data_req = 1; data_addr = 32'h0000_0400; mem_addr_ok = 1;
    #2;
    checks++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h0000_0400) begin errors++; $display("FAIL post_rst_req: got ack=%b addr=%h want 1/00000400", data_addr_ok, mem_addr); end
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_55aa;
    #2;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL post_rst_resp_ok: got i/d=%b want 01", {inst_data_ok, data_data_ok}); end
    checks++; if (data_rdata !== 32'h0000_55aa) begin errors++; $display("FAIL post_rst_rdata: got %h want 000055aa", data_rdata); end
    tick();
    mem_data_ok = 1;
    #2;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL post_rst_drained: got i/d=%b want 00", {inst_data_ok, data_data_ok}); end
    tick();
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_inst();
    test_both_same_cycle();
    test_starvation();
    test_lock_hold();
    test_full_wrap();
    test_spurious_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
